io_port_controller: RTL and testbench
=====================================

Name: io_port_controller

Overview:
- Peripheral-side I/O stage for the basic CPU.
- Input path: accepts words from an external device over a valid/ready handshake, holds each word for the CPU's INPR input and raises the input flag FGI.
- Output path: captures the CPU's OUTR word on an output-load strobe and drives it to an external consumer over valid/ready; FGO indicates the output side is free.
- Holds the interrupt-enable flip-flop (IEN) and produces the interrupt request.

Parameters:
- DATA_W, 16, width of data words on both paths.
- FIFO_DEPTH, 4, input FIFO depth; power of 2, at least 2; used only when IO_INPUT_FIFO_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- dev_in_data  in  DATA_W  word from the input device.
- dev_in_valid  in  1  dev_in_data is valid.
- dev_in_ready  out  1  block can accept an input word.
- inpr_data  out  DATA_W  word presented to the CPU INPR input.
- fgi  out  1  input flag: a word is available.
- cpu_inp_ack  in  1  one-cycle pulse; CPU executed INP and consumed inpr_data.
- cpu_out_load  in  1  one-cycle pulse; CPU wrote OUTR.
- cpu_out_data  in  DATA_W  OUTR value, sampled on cpu_out_load.
- fgo  out  1  output flag: output path is free.
- dev_out_data  out  DATA_W  word sent to the output device.
- dev_out_valid  out  1  dev_out_data is valid.
- dev_out_ready  in  1  output device accepts the word.
- cpu_ion  in  1  pulse; set IEN.
- cpu_iof  in  1  pulse; clear IEN.
- ien  out  1  interrupt enable.
- irq  out  1  interrupt request.
- io_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset values: dev_in_ready=1, fgi=0, inpr_data=0, fgo=1, dev_out_valid=0, dev_out_data=0, ien=0, io_err=0.
- Reset mid-operation drops any held or in-flight word in the cycle after reset is sampled.
- Input path, without the FIFO: two-state machine, IN_EMPTY and IN_FULL.
  - IN_EMPTY: dev_in_ready=1. When dev_in_valid is 1, latch dev_in_data into inpr_data; go to IN_FULL. fgi=1 on the next cycle (1-cycle latency).
  - IN_FULL: dev_in_ready=0 and inpr_data is held. cpu_inp_ack returns to IN_EMPTY: fgi=0 and dev_in_ready=1 on the next cycle. There is no same-cycle bypass.
  - inpr_data keeps the last word after the ack; it is not cleared.
  - cpu_inp_ack in IN_EMPTY is ignored for data and sets io_err.
- Output path: two-state machine, OUT_IDLE and OUT_BUSY.
  - OUT_IDLE: fgo=1. cpu_out_load latches cpu_out_data into dev_out_data; go to OUT_BUSY. On the next cycle fgo=0 and dev_out_valid=1.
  - OUT_BUSY: dev_out_valid=1 and dev_out_data are held stable until dev_out_valid and dev_out_ready are both 1. The cycle after that transfer: OUT_IDLE, fgo=1, dev_out_valid=0.
  - cpu_out_load in OUT_BUSY is ignored: the word is lost, the held data is unchanged, and io_err is set.
- Interrupts:
  - cpu_ion sets ien on the next cycle; cpu_iof clears it. If both are asserted, cpu_iof wins.
  - irq = ien & (fgi | fgo). It is combinational from registers only, so there is no input-to-output path.
- io_err: sticky; cleared only by reset.
- Input and output paths are independent; simultaneous events on both are handled in the same cycle.

Optional Feature:
- Macro: IO_INPUT_FIFO_EN.
- Defined: the input holding register is replaced by a FIFO of FIFO_DEPTH entries.
  - dev_in_ready = not full.
  - fgi = not empty.
  - inpr_data = head entry, shown combinationally from the FIFO storage.
  - cpu_inp_ack pops one entry.
  - Push and pop in the same cycle: the count is unchanged.
  - When full, dev_in_ready=0, so no push occurs.
  - Pointers wrap modulo FIFO_DEPTH.
  - Pop when empty: ignored, sets io_err.
- Undefined: the single-register IN_EMPTY/IN_FULL behaviour above applies, and FIFO_DEPTH is unused.

Decomposition:
- Package io_pkg holds:
  - IN_EMPTY/IN_FULL and OUT_IDLE/OUT_BUSY state encodings (1 bit each).
  - the default DATA_W constant.
- Sub-module io_in_fifo (parameters DATA_W and FIFO_DEPTH) contains the input FIFO. It is instantiated only under IO_INPUT_FIFO_EN.

Test Plan:
- Reset, then dev_in_data=16'h00A5 with dev_in_valid=1 for 1 cycle -> next cycle fgi=1, inpr_data=16'h00A5, dev_in_ready=0. Pulse cpu_inp_ack -> next cycle fgi=0, dev_in_ready=1, inpr_data still 16'h00A5.
- cpu_out_load with cpu_out_data=16'h1234 and dev_out_ready=0 for 3 cycles -> dev_out_valid=1, data stable, fgo=0. Then dev_out_ready=1 -> transfer; next cycle fgo=1, dev_out_valid=0.
- Second cpu_out_load (16'hBEEF) while busy -> dev_out_data stays 16'h1234, io_err=1 until reset.
- cpu_ion pulse with fgi=0 and fgo=1 -> irq=1. cpu_ion and cpu_iof together -> ien=0, irq=0.
- With IO_INPUT_FIFO_EN and FIFO_DEPTH=4: push 1,2,3,4 -> dev_in_ready=0. Push 5 attempted -> rejected. Pop 4 times -> inpr_data sequence 1,2,3,4, then fgi=0. Simultaneous push and pop at count 2 -> count stays 2.
- Reset asserted while OUT_BUSY and IN_FULL -> next cycle dev_out_valid=0, fgo=1, fgi=0, io_err=0.

Source files
------------

// File: rtl/io_pkg.sv
// io_pkg: shared constants and state encodings for the CPU I/O port controller.
// Optional feature macro used by this slice: IO_INPUT_FIFO_EN (input FIFO instead
// of the single input holding register).
package io_pkg;

  // Default word width on both the input and the output path.
  localparam int DATA_W_DEFAULT = 16;

  // Input holding register: either nothing for the CPU, or one word waiting.
  typedef enum logic {
    IN_EMPTY = 1'b0,
    IN_FULL  = 1'b1
  } in_state_e;

  // Output register: either free for a new OUTR word, or offering one to the device.
  typedef enum logic {
    OUT_IDLE = 1'b0,
    OUT_BUSY = 1'b1
  } out_state_e;

endpackage

// File: rtl/io_in_fifo.sv
// io_in_fifo: small input FIFO placed between the input device and the CPU
// INPR input. It is used by io_port_controller only when IO_INPUT_FIFO_EN is
// defined. The head entry is shown combinationally so the CPU sees the
// oldest word as soon as it lands. FIFO_DEPTH must be a power of two, at
// least 2, so that the pointers wrap by plain overflow.
module io_in_fifo
  import io_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_ok;
  logic              pop_ok;

  // A full FIFO refuses pushes and an empty one refuses pops, so neither
  // the count nor the pointers can run past their legal range.
  assign full_o      = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_o     = (count_q == '0);
  assign push_ok     = push_i & ~full_o;
  assign pop_ok      = pop_i & ~empty_o;
  assign head_data_o = mem_q[rd_ptr_q];

  // Pointer and occupancy update; push+pop together leaves the count alone.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage entries are cleared on reset so the head reads as zero before
  // the first word arrives, matching the single-register build.
  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
    // One storage word; written only when the write pointer selects it.
    always_ff @(posedge clk) begin
      if (reset) begin
        mem_q[gi] <= '0;
      end else if (push_ok && (wr_ptr_q == PTR_W'(gi))) begin
        mem_q[gi] <= push_data_i;
      end
    end
  end

endmodule

// File: rtl/io_port_controller.sv
// io_port_controller: peripheral-side I/O stage for the basic CPU.
//  - input path: device valid/ready -> INPR word + FGI flag
//  - output path: OUTR load strobe -> device valid/ready, FGO flag
//  - IEN flip-flop and interrupt request, sticky protocol-error flag
// Define IO_INPUT_FIFO_EN to replace the input holding register with an
// io_in_fifo of FIFO_DEPTH entries; otherwise FIFO_DEPTH is unused.
module io_port_controller
  import io_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  // input device side
  input  logic [DATA_W-1:0] dev_in_data,
  input  logic              dev_in_valid,
  output logic              dev_in_ready,
  // CPU input side
  output logic [DATA_W-1:0] inpr_data,
  output logic              fgi,
  input  logic              cpu_inp_ack,
  // CPU output side
  input  logic              cpu_out_load,
  input  logic [DATA_W-1:0] cpu_out_data,
  output logic              fgo,
  // output device side
  output logic [DATA_W-1:0] dev_out_data,
  output logic              dev_out_valid,
  input  logic              dev_out_ready,
  // interrupt control
  input  logic              cpu_ion,
  input  logic              cpu_iof,
  output logic              ien,
  output logic              irq,
  output logic              io_err
);

  // A bad depth has no sensible hardware; nothing is built for it here and
  // the FIFO pointer arithmetic assumes a power of two.
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_fifo_depth
  end

  logic in_err;   // CPU acknowledged input with nothing to consume
  logic out_err;  // CPU loaded OUTR while the previous word was still pending

  // ------------------------------------------------------------------
  // Input path
  // ------------------------------------------------------------------
`ifdef IO_INPUT_FIFO_EN

  logic fifo_full;
  logic fifo_empty;

  io_in_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_in_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (dev_in_valid),
    .push_data_i (dev_in_data),
    .pop_i       (cpu_inp_ack),
    .head_data_o (inpr_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign dev_in_ready = ~fifo_full;
  assign fgi          = ~fifo_empty;
  assign in_err       = cpu_inp_ack & fifo_empty;

`else

  in_state_e         in_state_q, in_state_d;
  logic [DATA_W-1:0] inpr_q, inpr_d;

  // Input state and INPR holding register.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_state_q <= IN_EMPTY;
      inpr_q     <= '0;
    end else begin
      in_state_q <= in_state_d;
      inpr_q     <= inpr_d;
    end
  end

  // Input next state: capture a device word when empty, release it on the
  // CPU ack. The ack only takes effect from IN_FULL, so a word never passes
  // straight through in one cycle, and INPR keeps its last value afterwards.
  always_comb begin
    in_state_d = in_state_q;
    inpr_d     = inpr_q;
    in_err     = 1'b0;
    case (in_state_q)
      IN_EMPTY: begin
        if (dev_in_valid) begin
          inpr_d     = dev_in_data;
          in_state_d = IN_FULL;
        end
        if (cpu_inp_ack) begin
          in_err = 1'b1;
        end
      end
      IN_FULL: begin
        if (cpu_inp_ack) begin
          in_state_d = IN_EMPTY;
        end
      end
      default: in_state_d = IN_EMPTY;
    endcase
  end

  assign dev_in_ready = (in_state_q == IN_EMPTY);
  assign fgi          = (in_state_q == IN_FULL);
  assign inpr_data    = inpr_q;

`endif

  // ------------------------------------------------------------------
  // Output path
  // ------------------------------------------------------------------
  out_state_e        out_state_q, out_state_d;
  logic [DATA_W-1:0] dout_q, dout_d;

  // Output state and OUTR-to-device data register.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_state_q <= OUT_IDLE;
      dout_q      <= '0;
    end else begin
      out_state_q <= out_state_d;
      dout_q      <= dout_d;
    end
  end

  // Output next state: take an OUTR word when idle, hold it stable until
  // the device accepts it. A load while busy is dropped and flagged.
  always_comb begin
    out_state_d = out_state_q;
    dout_d      = dout_q;
    out_err     = 1'b0;
    case (out_state_q)
      OUT_IDLE: begin
        if (cpu_out_load) begin
          dout_d      = cpu_out_data;
          out_state_d = OUT_BUSY;
        end
      end
      OUT_BUSY: begin
        if (cpu_out_load) begin
          out_err = 1'b1;
        end
        if (dev_out_ready) begin
          out_state_d = OUT_IDLE;
        end
      end
      default: out_state_d = OUT_IDLE;
    endcase
  end

  assign fgo           = (out_state_q == OUT_IDLE);
  assign dev_out_valid = (out_state_q == OUT_BUSY);
  assign dev_out_data  = dout_q;

  // ------------------------------------------------------------------
  // Interrupt enable and error flag
  // ------------------------------------------------------------------
  logic ien_q, ien_d;
  logic io_err_q, io_err_d;

  // IEN set/clear with clear taking priority; io_err only ever accumulates.
  always_comb begin
    ien_d    = ien_q;
    io_err_d = io_err_q | in_err | out_err;
    if (cpu_iof) begin
      ien_d = 1'b0;
    end else if (cpu_ion) begin
      ien_d = 1'b1;
    end
  end

  // IEN and sticky error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ien_q    <= 1'b0;
      io_err_q <= 1'b0;
    end else begin
      ien_q    <= ien_d;
      io_err_q <= io_err_d;
    end
  end

  assign ien    = ien_q;
  assign io_err = io_err_q;
  // Built only from registered flags, so no input reaches irq combinationally.
  assign irq    = ien_q & (fgi | fgo);

endmodule

// File: tb/tb_io_port_controller.sv
// tb_io_port_controller: self-checking bench for io_port_controller.
// Expected words are queued when stimulus is driven; output-device transfers
// are popped and compared by a negedge monitor, input words when the CPU
// consumes them.
module tb_io_port_controller;

  localparam int DW = 16;

  logic          clk;
  logic          reset;
  logic [DW-1:0] dev_in_data;
  logic          dev_in_valid;
  logic          dev_in_ready;
  logic [DW-1:0] inpr_data;
  logic          fgi;
  logic          cpu_inp_ack;
  logic          cpu_out_load;
  logic [DW-1:0] cpu_out_data;
  logic          fgo;
  logic [DW-1:0] dev_out_data;
  logic          dev_out_valid;
  logic          dev_out_ready;
  logic          cpu_ion;
  logic          cpu_iof;
  logic          ien;
  logic          irq;
  logic          io_err;

  io_port_controller #(.DATA_W(DW), .FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .dev_in_data   (dev_in_data),
    .dev_in_valid  (dev_in_valid),
    .dev_in_ready  (dev_in_ready),
    .inpr_data     (inpr_data),
    .fgi           (fgi),
    .cpu_inp_ack   (cpu_inp_ack),
    .cpu_out_load  (cpu_out_load),
    .cpu_out_data  (cpu_out_data),
    .fgo           (fgo),
    .dev_out_data  (dev_out_data),
    .dev_out_valid (dev_out_valid),
    .dev_out_ready (dev_out_ready),
    .cpu_ion       (cpu_ion),
    .cpu_iof       (cpu_iof),
    .ien           (ien),
    .irq           (irq),
    .io_err        (io_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] in_exp[$];
  logic [DW-1:0] out_exp[$];
  logic [DW-1:0] mon_exp;
  logic [DW-1:0] in_w;

  // Advance one clock; outputs are then read 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    in_exp.delete();
    out_exp.delete();
  endtask

  // Output scoreboard: a transfer happens at the next posedge when valid and
  // ready are both high at the negedge.
  always @(negedge clk) begin
    if (!reset && dev_out_valid && dev_out_ready) begin
      n_vec++;
      if (out_exp.size() == 0) begin
        n_err++;
        $display("FAIL out_unexpected: got %h, required no transfer", dev_out_data);
      end else begin
        mon_exp = out_exp.pop_front();
        if (dev_out_data !== mon_exp) begin
          n_err++;
          $display("FAIL out_word: got %h, required %h", dev_out_data, mon_exp);
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_vec++; if (dev_in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b, required 1", dev_in_ready); end
    n_vec++; if (fgi !== 1'b0) begin n_err++; $display("FAIL rst_fgi: got %b, required 0", fgi); end
    n_vec++; if (inpr_data !== 16'h0000) begin n_err++; $display("FAIL rst_inpr: got %h, required 0000", inpr_data); end
    n_vec++; if (fgo !== 1'b1) begin n_err++; $display("FAIL rst_fgo: got %b, required 1", fgo); end
    n_vec++; if (dev_out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b, required 0", dev_out_valid); end
    n_vec++; if (dev_out_data !== 16'h0000) begin n_err++; $display("FAIL rst_out_data: got %h, required 0000", dev_out_data); end
    n_vec++; if (ien !== 1'b0) begin n_err++; $display("FAIL rst_ien: got %b, required 0", ien); end
    n_vec++; if (io_err !== 1'b0) begin n_err++; $display("FAIL rst_io_err: got %b, required 0", io_err); end
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL rst_irq: got %b, required 0", irq); end
    reset = 1'b0;
  endtask

`ifndef IO_INPUT_FIFO_EN
  task automatic test_input();
    do_reset();
    dev_in_data = 16'h00A5; dev_in_valid = 1'b1; in_exp.push_back(16'h00A5);
    tick();
    dev_in_valid = 1'b0;
    n_vec++; if (fgi !== 1'b1) begin n_err++; $display("FAIL in_fgi_set: got %b, required 1", fgi); end
    n_vec++; if (dev_in_ready !== 1'b0) begin n_err++; $display("FAIL in_ready_full: got %b, required 0", dev_in_ready); end
    // A second word offered while full must not overwrite the held one.
    dev_in_data = 16'h5A5A; dev_in_valid = 1'b1;
    tick();
    dev_in_valid = 1'b0;
    in_w = in_exp.pop_front();
    n_vec++; if (inpr_data !== in_w) begin n_err++; $display("FAIL in_word: got %h, required %h", inpr_data, in_w); end
    cpu_inp_ack = 1'b1;
    tick();
    cpu_inp_ack = 1'b0;
    n_vec++; if (fgi !== 1'b0) begin n_err++; $display("FAIL in_fgi_clr: got %b, required 0", fgi); end
    n_vec++; if (dev_in_ready !== 1'b1) begin n_err++; $display("FAIL in_ready_back: got %b, required 1", dev_in_ready); end
    n_vec++; if (inpr_data !== 16'h00A5) begin n_err++; $display("FAIL in_keep_last: got %h, required 00a5", inpr_data); end
    n_vec++; if (io_err !== 1'b0) begin n_err++; $display("FAIL in_no_err: got %b, required 0", io_err); end
  endtask
`else
  task automatic test_fifo();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      n_vec++; if (dev_in_ready !== 1'b1) begin n_err++; $display("FAIL fifo_ready_%0d: got %b, required 1", i, dev_in_ready); end
      dev_in_data = DW'(i); dev_in_valid = 1'b1; in_exp.push_back(DW'(i));
      tick();
    end
    dev_in_valid = 1'b0;
    n_vec++; if (dev_in_ready !== 1'b0) begin n_err++; $display("FAIL fifo_full: got %b, required 0", dev_in_ready); end
    dev_in_data = 16'h0005; dev_in_valid = 1'b1;
    tick();
    dev_in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_w = in_exp.pop_front();
      n_vec++; if (inpr_data !== in_w) begin n_err++; $display("FAIL fifo_pop: got %h, required %h", inpr_data, in_w); end
      cpu_inp_ack = 1'b1;
      tick();
    end
    cpu_inp_ack = 1'b0;
    n_vec++; if (fgi !== 1'b0) begin n_err++; $display("FAIL fifo_empty: got %b, required 0", fgi); end
    // Build count 2, then push and pop in the same cycle.
    dev_in_data = 16'h0010; dev_in_valid = 1'b1; in_exp.push_back(16'h0010);
    tick();
    dev_in_data = 16'h0011; in_exp.push_back(16'h0011);
    tick();
    in_w = in_exp.pop_front();
    n_vec++; if (inpr_data !== in_w) begin n_err++; $display("FAIL fifo_head: got %h, required %h", inpr_data, in_w); end
    dev_in_data = 16'h0012; in_exp.push_back(16'h0012); cpu_inp_ack = 1'b1;
    tick();
    dev_in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_vec++; if (fgi !== 1'b1) begin n_err++; $display("FAIL fifo_cnt2_fgi: got %b, required 1", fgi); end
      in_w = in_exp.pop_front();
      n_vec++; if (inpr_data !== in_w) begin n_err++; $display("FAIL fifo_cnt2_word: got %h, required %h", inpr_data, in_w); end
      tick();
    end
    cpu_inp_ack = 1'b0;
    n_vec++; if (fgi !== 1'b0) begin n_err++; $display("FAIL fifo_cnt2_drained: got %b, required 0", fgi); end
    n_vec++; if (io_err !== 1'b0) begin n_err++; $display("FAIL fifo_no_err: got %b, required 0", io_err); end
  endtask
`endif

  task automatic test_input_err();
    do_reset();
    cpu_inp_ack = 1'b1;
    tick();
    cpu_inp_ack = 1'b0;
    n_vec++; if (io_err !== 1'b1) begin n_err++; $display("FAIL inerr_flag: got %b, required 1", io_err); end
    n_vec++; if (fgi !== 1'b0) begin n_err++; $display("FAIL inerr_fgi: got %b, required 0", fgi); end
    n_vec++; if (dev_in_ready !== 1'b1) begin n_err++; $display("FAIL inerr_ready: got %b, required 1", dev_in_ready); end
  endtask

  task automatic test_output();
    do_reset();
    dev_out_ready = 1'b0;
    cpu_out_data = 16'h1234; cpu_out_load = 1'b1; out_exp.push_back(16'h1234);
    tick();
    cpu_out_load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_vec++; if (dev_out_valid !== 1'b1) begin n_err++; $display("FAIL out_valid_hold%0d: got %b, required 1", k, dev_out_valid); end
      n_vec++; if (dev_out_data !== 16'h1234) begin n_err++; $display("FAIL out_data_hold%0d: got %h, required 1234", k, dev_out_data); end
      n_vec++; if (fgo !== 1'b0) begin n_err++; $display("FAIL out_fgo_busy%0d: got %b, required 0", k, fgo); end
      if (k == 1) begin
        cpu_out_data = 16'hBEEF; cpu_out_load = 1'b1;
      end
      tick();
      cpu_out_load = 1'b0;
    end
    n_vec++; if (io_err !== 1'b1) begin n_err++; $display("FAIL out_overrun_err: got %b, required 1", io_err); end
    n_vec++; if (dev_out_data !== 16'h1234) begin n_err++; $display("FAIL out_overrun_data: got %h, required 1234", dev_out_data); end
    dev_out_ready = 1'b1;
    tick();
    dev_out_ready = 1'b0;
    n_vec++; if (dev_out_valid !== 1'b0) begin n_err++; $display("FAIL out_valid_drop: got %b, required 0", dev_out_valid); end
    n_vec++; if (fgo !== 1'b1) begin n_err++; $display("FAIL out_fgo_free: got %b, required 1", fgo); end
    tick();
    tick();
    n_vec++; if (io_err !== 1'b1) begin n_err++; $display("FAIL out_err_sticky: got %b, required 1", io_err); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    dev_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cpu_out_data = 16'h1000 + DW'(i) * 16'h0111; cpu_out_load = 1'b1;
      out_exp.push_back(16'h1000 + DW'(i) * 16'h0111);
      if (i == 0) begin
        dev_in_data = 16'hC0DE; dev_in_valid = 1'b1; in_exp.push_back(16'hC0DE);
      end
      tick();
      cpu_out_load = 1'b0; dev_in_valid = 1'b0;
      n_vec++; if (dev_out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid%0d: got %b, required 1", i, dev_out_valid); end
      n_vec++; if (fgo !== 1'b0) begin n_err++; $display("FAIL b2b_fgo_busy%0d: got %b, required 0", i, fgo); end
      if (i == 0) begin
        n_vec++; if (fgi !== 1'b1) begin n_err++; $display("FAIL b2b_fgi: got %b, required 1", fgi); end
        in_w = in_exp.pop_front();
        n_vec++; if (inpr_data !== in_w) begin n_err++; $display("FAIL b2b_in_word: got %h, required %h", inpr_data, in_w); end
        cpu_inp_ack = 1'b1;
      end
      tick();
      cpu_inp_ack = 1'b0;
      n_vec++; if (fgo !== 1'b1) begin n_err++; $display("FAIL b2b_fgo_free%0d: got %b, required 1", i, fgo); end
    end
    dev_out_ready = 1'b0;
    n_vec++; if (fgi !== 1'b0) begin n_err++; $display("FAIL b2b_fgi_clr: got %b, required 0", fgi); end
    n_vec++; if (io_err !== 1'b0) begin n_err++; $display("FAIL b2b_no_err: got %b, required 0", io_err); end
  endtask

  task automatic test_interrupts();
    do_reset();
    dev_out_ready = 1'b0;
    cpu_ion = 1'b1;
    tick();
    cpu_ion = 1'b0;
    n_vec++; if (ien !== 1'b1) begin n_err++; $display("FAIL int_ien_set: got %b, required 1", ien); end
    n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL int_irq_fgo: got %b, required 1", irq); end
    cpu_ion = 1'b1; cpu_iof = 1'b1;
    tick();
    cpu_ion = 1'b0; cpu_iof = 1'b0;
    n_vec++; if (ien !== 1'b0) begin n_err++; $display("FAIL int_iof_wins: got %b, required 0", ien); end
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL int_irq_off: got %b, required 0", irq); end
    cpu_ion = 1'b1;
    tick();
    cpu_ion = 1'b0;
    // Output busy and no input word: both flags low, so no request.
    cpu_out_data = 16'h0042; cpu_out_load = 1'b1;
    tick();
    cpu_out_load = 1'b0;
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL int_irq_noflag: got %b, required 0", irq); end
    dev_in_data = 16'h0077; dev_in_valid = 1'b1; in_exp.push_back(16'h0077);
    tick();
    dev_in_valid = 1'b0;
    n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL int_irq_fgi: got %b, required 1", irq); end
    in_w = in_exp.pop_front();
    n_vec++; if (inpr_data !== in_w) begin n_err++; $display("FAIL int_in_word: got %h, required %h", inpr_data, in_w); end
    cpu_inp_ack = 1'b1;
    tick();
    cpu_inp_ack = 1'b0;
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL int_irq_consumed: got %b, required 0", irq); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    dev_out_ready = 1'b0;
    cpu_out_data = 16'h5555; cpu_out_load = 1'b1;
    dev_in_data = 16'h6666; dev_in_valid = 1'b1;
    tick();
    dev_in_valid = 1'b0;
    cpu_out_data = 16'h7777; cpu_ion = 1'b1;
    tick();
    cpu_out_load = 1'b0; cpu_ion = 1'b0;
    n_vec++; if (fgi !== 1'b1) begin n_err++; $display("FAIL mid_pre_fgi: got %b, required 1", fgi); end
    n_vec++; if (dev_out_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre_valid: got %b, required 1", dev_out_valid); end
    n_vec++; if (io_err !== 1'b1) begin n_err++; $display("FAIL mid_pre_err: got %b, required 1", io_err); end
    reset = 1'b1;
    tick();
    n_vec++; if (dev_out_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b, required 0", dev_out_valid); end
    n_vec++; if (fgo !== 1'b1) begin n_err++; $display("FAIL mid_fgo: got %b, required 1", fgo); end
    n_vec++; if (fgi !== 1'b0) begin n_err++; $display("FAIL mid_fgi: got %b, required 0", fgi); end
    n_vec++; if (io_err !== 1'b0) begin n_err++; $display("FAIL mid_io_err: got %b, required 0", io_err); end
    n_vec++; if (ien !== 1'b0) begin n_err++; $display("FAIL mid_ien: got %b, required 0", ien); end
    n_vec++; if (dev_in_ready !== 1'b1) begin n_err++; $display("FAIL mid_in_ready: got %b, required 1", dev_in_ready); end
    reset = 1'b0;
  endtask

  // Hard bound on the whole run in case the DUT or bench stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; dev_in_data = '0; dev_in_valid = 1'b0; cpu_inp_ack = 1'b0;
    cpu_out_load = 1'b0; cpu_out_data = '0; dev_out_ready = 1'b0;
    cpu_ion = 1'b0; cpu_iof = 1'b0;
    test_reset();
`ifndef IO_INPUT_FIFO_EN
    test_input();
`else
    test_fifo();
`endif
    test_input_err();
    test_output();
    test_back_to_back();
    test_interrupts();
    test_reset_midop();
    n_vec++; if (out_exp.size() != 0) begin n_err++; $display("FAIL out_pending: got %0d words left, required 0", out_exp.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
